doodle_vertical_physics: RTL and testbench
==========================================

Name: doodle_vertical_physics

Overview:
Per-frame vertical motion engine for the doodle. It integrates velocity and gravity and produces doodle_y, which feeds the platform collision observer. It consumes that observer's doodle_collision pulse and ground Y to bounce the doodle off platforms. It also emits camera-scroll requests to the platform scroller and signals game over when the doodle falls off screen.

Parameters:
JUMP_VEL, 20, upward launch speed in px/frame (applied as negative velocity)
GRAVITY, 1, px/frame added to velocity each frame
MAX_FALL, 20, downward velocity clamp in px/frame
DOODLE_H, 80, sprite height; feet are at doodle_y + DOODLE_H
SCROLL_LINE, 300, minimum on-screen doodle_y; anything higher is converted to scroll
SCREEN_BOTTOM, 767, last visible row
START_Y, 600, doodle_y in IDLE and after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-clk strobe, once per video frame
start  in  1  level; begins a game from IDLE, or returns DEAD to IDLE
doodle_collision  in  1  collision pulse from the observer (registered, may be one clk wide)
ground_y  in  10  platform top Y from the observer, valid with doodle_collision
doodle_y  out  10  doodle top Y, unsigned, 0 = top of screen
velocity  out  8  signed vertical velocity in px/frame, negative = up
state  out  3  current phase_t encoding, for debug and sprite selection
bounce  out  1  one-clk pulse on a platform bounce
scroll_valid  out  1  one-clk pulse when scroll_dy is valid
scroll_dy  out  10  px the world must move down this frame
game_over  out  1  high while in DEAD

Behaviour:
- Reset values (async assert; deassertion is synchronised by the system): doodle_y=START_Y, velocity=0, state=IDLE, bounce=0, scroll_valid=0, scroll_dy=0, game_over=0, pend=0.
- Collision latch:
  - In FALLING, any clk with doodle_collision=1 sets pend=1 and captures ground_y into pend_y.
  - A later pulse before the next tick overwrites pend_y.
  - A collision pulse on the same clk as frame_tick counts for that tick.
  - pend clears on every frame_tick and on leaving FALLING; collisions in other states are ignored.
- All state, position and velocity updates occur on the clk edge at which frame_tick=1. Outputs are visible the following cycle, so latency is 1 clk.
- IDLE:
  - doodle_y is held at START_Y and velocity at 0.
  - At a tick with start=1: velocity=-JUMP_VEL and go to RISING. Position does not change on that tick.
- RISING, at a tick:
  - ny = doodle_y + velocity, computed as a 12-bit signed sum.
  - If ny < SCROLL_LINE: doodle_y=SCROLL_LINE, scroll_dy=SCROLL_LINE-ny, and pulse scroll_valid. Otherwise doodle_y=ny.
  - Then velocity += GRAVITY.
  - If the new velocity >= 0, go to FALLING.
- FALLING, at a tick:
  - If pend (or a same-clk collision): doodle_y = pend_y - DOODLE_H (clamped at 0), velocity=-JUMP_VEL, pulse bounce, go to RISING. There is no integration on that tick.
  - Otherwise: ny = doodle_y + velocity, then velocity = min(velocity+GRAVITY, MAX_FALL).
  - If ny > SCREEN_BOTTOM: go to DEAD with doodle_y = SCREEN_BOTTOM. Otherwise doodle_y=ny.
- DEAD:
  - game_over=1 and all motion is held.
  - At a tick with start=1: go to IDLE, doodle_y=START_Y, velocity=0.
- scroll_valid and bounce are low in every cycle other than the one following the qualifying tick. scroll_dy holds its last value.
- Arithmetic uses 12-bit signed internally. doodle_y never wraps: it is clamped to [0, SCREEN_BOTTOM].
- Reset during any state returns immediately to reset values. A pending collision is discarded.

Decomposition:
- Package doodle_pkg holds:
  - phase_t enum: IDLE, RISING, FALLING, DEAD.
  - Constants: Y_W=10, X_W=11, VEL_W=8, DOODLE_H=80, SCREEN_BOTTOM=767.
  - The collision observer also uses these constants.
- Sub-module doodle_collision_latch holds pend/pend_y with its set, overwrite and clear-on-tick rules. The main block keeps the FSM and integrator.

Test Plan:
- Reset then start=1 at a tick: state RISING, velocity -20, y 600. After 20 further ticks: y=390, velocity 0, state FALLING, no scroll pulses.
- START_Y=320: tick 1 gives y=300 with no scroll. Tick 2 gives y=300, scroll_valid for 1 clk, scroll_dy=19.
- In FALLING at y=400, pulse doodle_collision with ground_y=500 two clks before a tick. After the tick: y=420, velocity -20, bounce for 1 clk, state RISING. Next tick: y=400.
- FALLING with no collisions for 30 ticks: velocity saturates at 20 and never exceeds it. Once y passes 767: state DEAD, game_over=1, y=767. start at a tick returns to IDLE with y=600.
- Collision pulse while RISING, then the apex is reached: the pulse is ignored, with no bounce at the first FALLING tick.
- Assert rst mid-FALLING with pend=1: outputs take reset values immediately, and the first post-reset ticks with start=0 stay in IDLE.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared types and screen/sprite geometry for the doodle vertical-motion path
// and the platform collision observer.
package doodle_pkg;
  localparam int Y_W           = 10;
  localparam int X_W           = 11;
  localparam int VEL_W         = 8;
  localparam int CALC_W        = 12;
  localparam int DOODLE_H      = 80;
  localparam int SCREEN_BOTTOM = 767;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISING  = 3'd1,
    FALLING = 3'd2,
    DEAD    = 3'd3
  } phase_t;

  function automatic logic signed [CALC_W-1:0] sext_vel(input logic [VEL_W-1:0] v);
    return {{(CALC_W-VEL_W){v[VEL_W-1]}}, v};
  endfunction
endpackage

// File: rtl/doodle_collision_latch.sv
// Holds a platform hit seen between frame ticks; the newest pulse wins and a
// pulse on the tick clk itself is forwarded combinationally.
module doodle_collision_latch
  import doodle_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           collision,
  input  logic [Y_W-1:0] ground_y,
  output logic           hit,
  output logic [Y_W-1:0] hit_y
);
  logic           pend;
  logic [Y_W-1:0] pend_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      pend_y <= '0;
    end else if (frame_tick || !enable) begin
      pend <= 1'b0;
    end else if (collision) begin
      pend   <= 1'b1;
      pend_y <= ground_y;
    end
  end

  assign hit   = enable && (pend || collision);
  assign hit_y = (enable && collision) ? ground_y : pend_y;
endmodule

// File: rtl/doodle_vertical_physics.sv
// Per-frame vertical integrator and game-phase FSM for the doodle: jump,
// gravity, platform bounce, camera scroll above SCROLL_LINE and fall-off death.
module doodle_vertical_physics
  import doodle_pkg::*;
#(
  parameter int JUMP_VEL      = 20,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 20,
  parameter int DOODLE_H      = doodle_pkg::DOODLE_H,
  parameter int SCROLL_LINE   = 300,
  parameter int SCREEN_BOTTOM = doodle_pkg::SCREEN_BOTTOM,
  parameter int START_Y       = 600
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    doodle_collision,
  input  logic [Y_W-1:0]          ground_y,
  output logic [Y_W-1:0]          doodle_y,
  output logic signed [VEL_W-1:0] velocity,
  output logic [2:0]              state,
  output logic                    bounce,
  output logic                    scroll_valid,
  output logic [Y_W-1:0]          scroll_dy,
  output logic                    game_over
);
  localparam logic signed [CALC_W-1:0] GRAV_S = CALC_W'(GRAVITY);
  localparam logic signed [CALC_W-1:0] MF_S   = CALC_W'(MAX_FALL);
  localparam logic signed [CALC_W-1:0] H_S    = CALC_W'(DOODLE_H);
  localparam logic signed [CALC_W-1:0] SL_S   = CALC_W'(SCROLL_LINE);
  localparam logic signed [CALC_W-1:0] SB_S   = CALC_W'(SCREEN_BOTTOM);
  localparam logic [Y_W-1:0]           START_V  = Y_W'(START_Y);
  localparam logic [Y_W-1:0]           SL_V     = Y_W'(SCROLL_LINE);
  localparam logic [Y_W-1:0]           SB_V     = Y_W'(SCREEN_BOTTOM);
  localparam logic [VEL_W-1:0]         LAUNCH_V = VEL_W'(-JUMP_VEL);

  phase_t                    phase;
  logic                      hit;
  logic [Y_W-1:0]            hit_y;
  logic signed [CALC_W-1:0]  y_s, v_s, ny, nv, nv_fall, land, sdy;

  doodle_collision_latch u_latch (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (phase == FALLING),
    .collision  (doodle_collision),
    .ground_y   (ground_y),
    .hit        (hit),
    .hit_y      (hit_y)
  );

  always_comb begin
    y_s     = {{(CALC_W-Y_W){1'b0}}, doodle_y};
    v_s     = sext_vel(velocity);
    ny      = y_s + v_s;
    nv      = v_s + GRAV_S;
    nv_fall = (nv > MF_S) ? MF_S : nv;
    land    = {{(CALC_W-Y_W){1'b0}}, hit_y} - H_S;
    sdy     = SL_S - ny;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= IDLE;
      doodle_y     <= START_V;
      velocity     <= '0;
      bounce       <= 1'b0;
      scroll_valid <= 1'b0;
      scroll_dy    <= '0;
      game_over    <= 1'b0;
    end else begin
      bounce       <= 1'b0;
      scroll_valid <= 1'b0;
      if (frame_tick) begin
        case (phase)
          IDLE: begin
            doodle_y <= START_V;
            velocity <= '0;
            if (start) begin
              velocity <= LAUNCH_V;
              phase    <= RISING;
            end
          end
          RISING: begin
            // Anything above the scroll line is handed to the scroller instead.
            if (ny < SL_S) begin
              doodle_y     <= SL_V;
              scroll_dy    <= sdy[Y_W-1:0];
              scroll_valid <= 1'b1;
            end else if (ny > SB_S) begin
              doodle_y <= SB_V;
            end else begin
              doodle_y <= ny[Y_W-1:0];
            end
            velocity <= nv[VEL_W-1:0];
            if (!nv[CALC_W-1]) phase <= FALLING;
          end
          FALLING: begin
            if (hit) begin
              if (land < 0)         doodle_y <= '0;
              else if (land > SB_S) doodle_y <= SB_V;
              else                  doodle_y <= land[Y_W-1:0];
              velocity <= LAUNCH_V;
              bounce   <= 1'b1;
              phase    <= RISING;
            end else begin
              velocity <= nv_fall[VEL_W-1:0];
              if (ny > SB_S) begin
                doodle_y  <= SB_V;
                phase     <= DEAD;
                game_over <= 1'b1;
              end else if (ny < 0) begin
                doodle_y <= '0;
              end else begin
                doodle_y <= ny[Y_W-1:0];
              end
            end
          end
          DEAD: begin
            if (start) begin
              phase     <= IDLE;
              doodle_y  <= START_V;
              velocity  <= '0;
              game_over <= 1'b0;
            end
          end
          default: phase <= IDLE;
        endcase
      end
    end
  end

  assign state = phase;
endmodule

// File: tb/tb_doodle_vertical_physics.sv
// Directed scenarios for the doodle vertical physics engine with hand-derived
// trajectories; a second instance with START_Y=320 exercises camera scroll.
module tb_doodle_vertical_physics;
  logic       clk, rst, frame_tick, start, doodle_collision;
  logic [9:0] ground_y;

  logic [9:0]        a_y, a_dy, b_y, b_dy;
  logic signed [7:0] a_vel, b_vel;
  logic [2:0]        a_state, b_state;
  logic              a_bounce, a_sv, a_go, b_bounce, b_sv, b_go;

  int total = 0;
  int bad   = 0;

  doodle_vertical_physics u_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .doodle_collision(doodle_collision), .ground_y(ground_y),
    .doodle_y(a_y), .velocity(a_vel), .state(a_state), .bounce(a_bounce),
    .scroll_valid(a_sv), .scroll_dy(a_dy), .game_over(a_go)
  );

  doodle_vertical_physics #(.START_Y(320)) u_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
    .doodle_collision(doodle_collision), .ground_y(ground_y),
    .doodle_y(b_y), .velocity(b_vel), .state(b_state), .bounce(b_bounce),
    .scroll_valid(b_sv), .scroll_dy(b_dy), .game_over(b_go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic s);
    @(negedge clk);
    frame_tick = 1'b1;
    start      = s;
    @(negedge clk);
    frame_tick = 1'b0;
    start      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; doodle_collision = 1'b0; ground_y = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (a_y !== 10'd600) begin bad++; $display("FAIL reset_y got=%0d want=600", a_y); end
    total++; if (a_vel !== 8'sd0) begin bad++; $display("FAIL reset_vel got=%0d want=0", a_vel); end
    total++; if (a_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", a_state); end
    total++; if ({a_bounce, a_sv, a_go} !== 3'b000 || a_dy !== 10'd0) begin
      bad++; $display("FAIL reset_flags got=%b dy=%0d want=000 dy=0", {a_bounce, a_sv, a_go}, a_dy); end
    total++; if (b_y !== 10'd320) begin bad++; $display("FAIL reset_b_y got=%0d want=320", b_y); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_rise();
    int sv_cnt = 0;
    do_reset();
    tick(1'b1);
    total++; if (a_state !== 3'd1 || a_vel !== -8'sd20 || a_y !== 10'd600) begin
      bad++; $display("FAIL start got st=%0d v=%0d y=%0d want st=1 v=-20 y=600", a_state, a_vel, a_y); end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (a_sv) sv_cnt++;
      if (i == 9) begin
        total++; if (a_y !== 10'd445 || a_vel !== -8'sd10) begin
          bad++; $display("FAIL rise_mid got y=%0d v=%0d want y=445 v=-10", a_y, a_vel); end
      end
    end
    total++; if (a_y !== 10'd390 || a_vel !== 8'sd0 || a_state !== 3'd2) begin
      bad++; $display("FAIL apex got y=%0d v=%0d st=%0d want y=390 v=0 st=2", a_y, a_vel, a_state); end
    total++; if (sv_cnt !== 0) begin bad++; $display("FAIL rise_no_scroll got=%0d want=0", sv_cnt); end
  endtask

  // Continues from the apex: y 390 v 0 in FALLING.
  task automatic test_bounce();
    ticks(5);
    total++; if (a_y !== 10'd400 || a_vel !== 8'sd5) begin
      bad++; $display("FAIL fall_pre got y=%0d v=%0d want y=400 v=5", a_y, a_vel); end
    @(negedge clk);
    doodle_collision = 1'b1; ground_y = 10'd500;
    @(negedge clk);
    doodle_collision = 1'b0; ground_y = 10'd0;
    tick(1'b0);
    total++; if (a_y !== 10'd420 || a_vel !== -8'sd20 || a_state !== 3'd1) begin
      bad++; $display("FAIL bounce got y=%0d v=%0d st=%0d want y=420 v=-20 st=1", a_y, a_vel, a_state); end
    total++; if (a_bounce !== 1'b1) begin bad++; $display("FAIL bounce_pulse got=%b want=1", a_bounce); end
    @(negedge clk);
    total++; if (a_bounce !== 1'b0) begin bad++; $display("FAIL bounce_width got=%b want=0", a_bounce); end
    tick(1'b0);
    total++; if (a_y !== 10'd400 || a_bounce !== 1'b0) begin
      bad++; $display("FAIL post_bounce got y=%0d b=%b want y=400 b=0", a_y, a_bounce); end
  endtask

  task automatic test_scroll();
    do_reset();
    tick(1'b1);
    tick(1'b0);
    total++; if (b_y !== 10'd300 || b_sv !== 1'b0) begin
      bad++; $display("FAIL scroll_t1 got y=%0d sv=%b want y=300 sv=0", b_y, b_sv); end
    tick(1'b0);
    total++; if (b_y !== 10'd300 || b_sv !== 1'b1 || b_dy !== 10'd19) begin
      bad++; $display("FAIL scroll_t2 got y=%0d sv=%b dy=%0d want y=300 sv=1 dy=19", b_y, b_sv, b_dy); end
    @(negedge clk);
    total++; if (b_sv !== 1'b0 || b_dy !== 10'd19) begin
      bad++; $display("FAIL scroll_hold got sv=%b dy=%0d want sv=0 dy=19", b_sv, b_dy); end
  endtask

  task automatic test_fall_dead();
    int over = 0;
    do_reset();
    tick(1'b1);
    ticks(20);
    for (int i = 0; i < 29; i++) begin
      tick(1'b0);
      if (a_vel > 8'sd20 || a_state !== 3'd2) over++;
    end
    total++; if (over !== 0) begin bad++; $display("FAIL fall_sat got=%0d want=0", over); end
    total++; if (a_y !== 10'd760 || a_vel !== 8'sd20) begin
      bad++; $display("FAIL fall_760 got y=%0d v=%0d want y=760 v=20", a_y, a_vel); end
    tick(1'b0);
    total++; if (a_state !== 3'd3 || a_go !== 1'b1 || a_y !== 10'd767) begin
      bad++; $display("FAIL dead got st=%0d go=%b y=%0d want st=3 go=1 y=767", a_state, a_go, a_y); end
    tick(1'b0);
    total++; if (a_state !== 3'd3 || a_y !== 10'd767) begin
      bad++; $display("FAIL dead_hold got st=%0d y=%0d want st=3 y=767", a_state, a_y); end
    tick(1'b1);
    total++; if (a_state !== 3'd0 || a_y !== 10'd600 || a_vel !== 8'sd0 || a_go !== 1'b0) begin
      bad++; $display("FAIL restart got st=%0d y=%0d v=%0d go=%b want 0 600 0 0", a_state, a_y, a_vel, a_go); end
  endtask

  task automatic test_rise_collision_ignored();
    do_reset();
    tick(1'b1);
    ticks(5);
    @(negedge clk);
    doodle_collision = 1'b1; ground_y = 10'd500;
    @(negedge clk);
    doodle_collision = 1'b0;
    ticks(14);
    @(negedge clk);
    frame_tick = 1'b1; doodle_collision = 1'b1; ground_y = 10'd450;
    @(negedge clk);
    frame_tick = 1'b0; doodle_collision = 1'b0; ground_y = 10'd0;
    total++; if (a_state !== 3'd2 || a_y !== 10'd390 || a_vel !== 8'sd0) begin
      bad++; $display("FAIL rise_ign_apex got st=%0d y=%0d v=%0d want 2 390 0", a_state, a_y, a_vel); end
    tick(1'b0);
    total++; if (a_bounce !== 1'b0 || a_state !== 3'd2 || a_y !== 10'd390 || a_vel !== 8'sd1) begin
      bad++; $display("FAIL rise_ign_fall got b=%b st=%0d y=%0d v=%0d want 0 2 390 1", a_bounce, a_state, a_y, a_vel); end
  endtask

  task automatic test_reset_mid_fall();
    do_reset();
    tick(1'b1);
    ticks(22);
    @(negedge clk);
    doodle_collision = 1'b1; ground_y = 10'd500;
    @(negedge clk);
    doodle_collision = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (a_y !== 10'd600 || a_vel !== 8'sd0 || a_state !== 3'd0 || a_bounce !== 1'b0) begin
      bad++; $display("FAIL async_rst got y=%0d v=%0d st=%0d b=%b want 600 0 0 0", a_y, a_vel, a_state, a_bounce); end
    @(negedge clk);
    rst = 1'b0;
    ticks(2);
    total++; if (a_state !== 3'd0 || a_y !== 10'd600 || a_vel !== 8'sd0 || a_bounce !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle got st=%0d y=%0d v=%0d b=%b want 0 600 0 0", a_state, a_y, a_vel, a_bounce); end
  endtask

  initial begin
    test_reset();
    test_start_rise();
    test_bounce();
    test_scroll();
    test_fall_dead();
    test_rise_collision_ignored();
    test_reset_mid_fall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
